uart_tx_stream: RTL and testbench

Parametrised UART transmitter that succeeds the fixed-format 8N1 transmitter. Accepts words over a valid/ready stream, serialises them LSB-first with a start bit, 5–9 data bits, an optional even/odd parity bit and one or two stop bits, at a runtime-programmable bit period. Sits between a processor or DMA stream and the TX pad. An optional input FIFO decouples bursty producers from the line rate.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_stream.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: engine state type, parity-mode encodings and divisor floor
// shared by the stream UART transmitter and its optional input FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_DIV = 2;

  // Mode 2'b11 is a second encoding of "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  // A push at full is refused even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only ever read behind level_q,
  // so flushing the pointers is enough and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: valid/ready fed UART transmitter, 5-9 data bits, optional
// parity, 1/2 stop bits. Define UART_TX_FIFO_EN to add the input FIFO.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  logic [DATA_WIDTH-1:0] word;
  logic                  word_avail;
  logic                  eng_ready;
  logic                  take;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (take),
    .rdata (word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign word_avail = !fifo_empty;
  assign s_ready    = rst_n && !fifo_full;
`else
  assign word       = s_data;
  assign word_avail = s_valid;
  assign s_ready    = rst_n && eng_ready;
  assign fifo_level = '0;
`endif

  tx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic                  cnt_wrap;
  logic                  last_stop;

  assign div_eff   = (cfg_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : cfg_div;
  assign cnt_wrap  = (cnt_q == div_q - DIV_WIDTH'(1));
  assign last_stop = (state_q == STOP) && cnt_wrap && (bit_q == {3'b000, stop2_q});
  // Accepting on the final stop cycle lets frames run back to back.
  assign eng_ready = (state_q == IDLE) || last_stop;
  assign take      = eng_ready && word_avail;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    done_d   = 1'b0;

    if (state_q != IDLE) cnt_d = cnt_wrap ? '0 : cnt_q + DIV_WIDTH'(1);

    case (state_q)
      IDLE: ;
      START: begin
        if (cnt_wrap) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          if (bit_q == 4'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (cnt_wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (last_stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
          tx_d    = 1'b1;
        end else if (cnt_wrap) begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line settings are captured with the word so mid-frame edits wait.
    if (take) begin
      state_d  = START;
      cnt_d    = '0;
      bit_d    = '0;
      shift_d  = word;
      div_d    = div_eff;
      par_en_d = parity_enabled(cfg_parity);
      par_d    = (^word) ^ (cfg_parity == PAR_ODD);
      stop2_d  = cfg_stop2;
      tx_d     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed and random bursts checked cycle by cycle
// against a frame model; works with or without UART_TX_FIFO_EN.
`timescale 1ns/1ps
module tb_uart_tx_stream;

  localparam int DW    = 8;
  localparam int DIVW  = 16;
  localparam int DEPTH = 4;
  localparam int LVW   = $clog2(DEPTH) + 1;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
  localparam int LAT     = 1;
`else
  localparam bit FIFO_ON = 1'b0;
  localparam int LAT     = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DIVW-1:0] cfg_div = '0;
  logic [1:0]      cfg_parity = '0;
  logic            cfg_stop2 = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            tx;
  logic            tx_busy;
  logic            tx_done;
  logic [LVW-1:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] wq [8];

  always #5 clk = ~clk;

  uart_tx_stream #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (DIVW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_div(input int div);
    return (div < 2) ? 2 : div;
  endfunction

  function automatic int frame_len(input int div, input int par, input bit stop2);
    int p;
    p = (par == 1 || par == 2) ? 1 : 0;
    return (1 + DW + p + (stop2 ? 2 : 1)) * eff_div(div);
  endfunction

  // Line level of bit slot b of a frame carrying w.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int b, input int par);
    int ones;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (b == DW + 1 && (par == 1 || par == 2)) begin
      ones = 0;
      for (int i = 0; i < DW; i++) ones += int'(w[i]);
      return ((ones % 2) == 1) ^ (par == 2);
    end
    return 1'b1;
  endfunction

  // Presents wq[0..n-1] continuously and checks every cycle of the resulting
  // back-to-back frames, counting t from the first handshake edge.
  task automatic run_burst(input string name, input int n, input int div,
                           input int par, input bit stop2);
    int   len, deff, total, fed, level_m, k, idx;
    bit   hs_pending, exp_busy, exp_done, exp_ready;
    logic exp_tx;
    deff  = eff_div(div);
    len   = frame_len(div, par, stop2);
    total = n * len;
    @(negedge clk);
    cfg_div    = DIVW'(div);
    cfg_parity = 2'(par);
    cfg_stop2  = stop2;
    s_data     = wq[0];
    s_valid    = 1'b1;
    check({name, ".ready_idle"}, 32'(s_ready), 32'd1);
    hs_pending = 1'b1;
    fed        = 0;
    level_m    = 0;
    for (int t = 0; t <= LAT + total; t++) begin
      @(negedge clk);
      if (FIFO_ON) begin
        if (hs_pending) level_m++;
        if (t >= LAT && t < LAT + total && ((t - LAT) % len) == 0) level_m--;
      end
      exp_busy = (t >= LAT) && (t < LAT + total);
      exp_done = (t > LAT) && (((t - LAT) % len) == 0) && ((t - LAT) <= total);
      if (exp_busy) begin
        k      = (t - LAT) / len;
        idx    = (t - LAT) % len;
        exp_tx = frame_bit(wq[k], idx / deff, par);
      end else begin
        exp_tx = 1'b1;
      end
      if (FIFO_ON) exp_ready = (level_m < DEPTH);
      else         exp_ready = !exp_busy || (((t + 1 - LAT) % len) == 0);
      check({name, ".tx"},    32'(tx),      32'(exp_tx));
      check({name, ".busy"},  32'(tx_busy), 32'(exp_busy));
      check({name, ".done"},  32'(tx_done), 32'(exp_done));
      check({name, ".ready"}, 32'(s_ready), 32'(exp_ready));
      check({name, ".level"}, 32'(fifo_level), FIFO_ON ? 32'(level_m) : 32'd0);
      if (hs_pending) begin
        fed++;
        if (fed < n) s_data = wq[fed];
        else         s_valid = 1'b0;
        hs_pending = 1'b0;
      end
      if (s_valid && s_ready) hs_pending = 1'b1;
      // Scramble settings once the last frame has captured its own.
      if (t == LAT + (n - 1) * len + 1) begin
        cfg_div    = DIVW'($urandom_range(0, 15));
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    check({name, ".done_clear"}, 32'(tx_done), 32'd0);
    check({name, ".idle"},       32'(tx_busy), 32'd0);
    check({name, ".accepted"},   32'(fed),     32'(n));
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("reset.tx",    32'(tx),         32'd1);
    check("reset.busy",  32'(tx_busy),    32'd0);
    check("reset.done",  32'(tx_done),    32'd0);
    check("reset.ready", 32'(s_ready),    32'd0);
    check("reset.level", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wq[0] = 8'hA5;
    run_burst("8n1_div4", 1, 4, 0, 1'b0);
    wq[0] = 8'h07;
    run_burst("even_div3", 1, 3, 1, 1'b0);
    run_burst("odd_div3", 1, 3, 2, 1'b0);
    run_burst("par11_div3", 1, 3, 3, 1'b0);
    wq[0] = 8'h1F;
    run_burst("stop2_div0", 1, 0, 0, 1'b1);
    wq[0] = 8'hFF;
    run_burst("stop2_div1", 1, 1, 1, 1'b1);
    wq[0] = 8'h55;
    wq[1] = 8'hAA;
    run_burst("b2b", 2, 4, 0, 1'b0);
    for (int i = 0; i < 6; i++) wq[i] = DW'(i + 1);
    run_burst("burst6", 6, 8, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wq[i] = DW'($urandom);
      run_burst($sformatf("rand%0d", r), n, $urandom_range(0, 6),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Abort a frame about ten cycles in.
    @(negedge clk);
    cfg_div    = DIVW'(5);
    cfg_parity = 2'd1;
    cfg_stop2  = 1'b0;
    s_data     = 8'h3C;
    s_valid    = 1'b1;
    for (int i = 0; i < (FIFO_ON ? 3 : 1); i++) begin
      @(negedge clk);
      s_data = s_data + 8'd1;
    end
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("midframe.busy",  32'(tx_busy),    32'd1);
    check("midframe.level", 32'(fifo_level), FIFO_ON ? 32'd2 : 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort.tx",    32'(tx),         32'd1);
    check("abort.busy",  32'(tx_busy),    32'd0);
    check("abort.done",  32'(tx_done),    32'd0);
    check("abort.ready", 32'(s_ready),    32'd0);
    check("abort.level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    check("abort.hold_tx", 32'(tx), 32'd1);
    rst_n = 1'b1;
    wq[0] = 8'hC3;
    run_burst("after_reset", 1, 3, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
